// File: rtl/fe_exp_sequencer.sv
// Modular exponentiation a^EXPONENT mod 2^255-19 by left-to-right
// square-and-multiply, driving an external reducing field multiplier.
module fe_exp_sequencer #(
  parameter int             BIT_LENGTH = 256,
  parameter logic [254:0]   EXPONENT   = ~255'd0 - 255'd20,
  parameter int             EXP_BITS   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIT_LENGTH-1:0]   a_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIT_LENGTH-1:0]   result,
  output logic                    mul_rst,
  output logic                    mul_redux,
  output logic [BIT_LENGTH-1:0]   mul_a,
  output logic [BIT_LENGTH-1:0]   mul_b,
  input  logic [2*BIT_LENGTH-1:0] mul_u,
  input  logic                    mul_valid
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQ_KICK,
    SQ_WAIT,
    MUL_KICK,
    MUL_WAIT,
    FIN
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [BIT_LENGTH-1:0]   base;
  logic [BIT_LENGTH-1:0]   acc;
  logic [7:0]              idx;
  logic                    exp_bit;
  logic                    last;
  logic [BIT_LENGTH-1:0]   prod;
  logic                    mul_u_unused;

  // The multiplier reduces, so the upper product half is never needed.
  assign prod         = mul_u[BIT_LENGTH-1:0];
  assign mul_u_unused = ^mul_u[2*BIT_LENGTH-1:BIT_LENGTH];
  assign exp_bit      = EXPONENT[idx];
  assign last         = (idx == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start) state_nx = LOAD;
      LOAD:     state_nx = SQ_KICK;
      SQ_KICK:  state_nx = SQ_WAIT;
      SQ_WAIT: begin
        if (mul_valid) begin
          if (exp_bit)   state_nx = MUL_KICK;
          else if (last) state_nx = FIN;
          else           state_nx = SQ_KICK;
        end
      end
      MUL_KICK: state_nx = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_valid) state_nx = last ? FIN : SQ_KICK;
      end
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mul_redux = 1'b1;
    unique case (state)
      IDLE:    busy = 1'b0;
      FIN:     done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // Multiplier is held in reset everywhere except while a product is awaited.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_rst <= 1'b1;
      base    <= '0;
      acc     <= '0;
      idx     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      result  <= '0;
    end else begin
      mul_rst <= !(state_nx == SQ_WAIT || state_nx == MUL_WAIT);
      unique case (state)
        IDLE: begin
          if (start) begin
            base <= a_in;
            acc  <= a_in;
            idx  <= 8'(EXP_BITS - 2);
          end
        end
        SQ_KICK: begin
          mul_a <= acc;
          mul_b <= acc;
        end
        SQ_WAIT: begin
          if (mul_valid) begin
            acc <= prod;
            if (!exp_bit && !last) idx <= idx - 8'd1;
          end
        end
        MUL_KICK: begin
          mul_a <= acc;
          mul_b <= base;
        end
        MUL_WAIT: begin
          if (mul_valid) begin
            acc <= prod;
            if (!last) idx <= idx - 8'd1;
          end
        end
        FIN:     result <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fe_exp_sequencer.sv
// Bench for fe_exp_sequencer: behavioural field multipliers with
// programmable latency, scoreboard of expected results.
module tb_fe_exp_sequencer;

  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         start0 = 1'b0;
  logic [255:0] a0 = '0;
  logic         busy0, done0, mul_rst0, mul_redux0, mul_valid0;
  logic [255:0] result0, mul_a0, mul_b0;
  logic [511:0] mul_u0;

  logic         start1 = 1'b0;
  logic [255:0] a1 = '0;
  logic         busy1, done1, mul_rst1, mul_redux1, mul_valid1;
  logic [255:0] result1, mul_a1, mul_b1;
  logic [511:0] mul_u1;

  fe_exp_sequencer u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a_in(a0),
    .busy(busy0), .done(done0), .result(result0),
    .mul_rst(mul_rst0), .mul_redux(mul_redux0),
    .mul_a(mul_a0), .mul_b(mul_b0),
    .mul_u(mul_u0), .mul_valid(mul_valid0)
  );

  fe_exp_sequencer #(
    .BIT_LENGTH(256), .EXPONENT(255'd5), .EXP_BITS(3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1),
    .busy(busy1), .done(done1), .result(result1),
    .mul_rst(mul_rst1), .mul_redux(mul_redux1),
    .mul_a(mul_a1), .mul_b(mul_b1),
    .mul_u(mul_u1), .mul_valid(mul_valid1)
  );

  function automatic logic [255:0] mm(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] p;
    p = {256'b0, x} * {256'b0, y};
    p = p % {256'b0, P};
    return p[255:0];
  endfunction

  // Behavioural multipliers: valid Lm cycles after the last reset cycle.
  int   lm0 = 4;
  int   lm1 = 1;
  int   cnt0 = 0;
  int   cnt1 = 0;
  int   hold1 = 0;
  bit   hold_en = 1'b0;
  logic base1;

  always @(posedge clk) begin
    if (mul_rst0 !== 1'b0) cnt0 <= 0;
    else if (cnt0 < 100000) cnt0 <= cnt0 + 1;
    if (mul_rst1 !== 1'b0) cnt1 <= 0;
    else if (cnt1 < 100000) cnt1 <= cnt1 + 1;
    if (hold_en && base1 && hold1 == 0) hold1 <= 2;
    else if (hold1 > 0) hold1 <= hold1 - 1;
  end

  always_comb begin
    mul_u0     = {256'b0, mm(mul_a0, mul_b0)};
    mul_valid0 = (mul_rst0 === 1'b0) && (cnt0 >= lm0 - 1);
    mul_u1     = {256'b0, mm(mul_a1, mul_b1)};
    base1      = (mul_rst1 === 1'b0) && (cnt1 >= lm1 - 1);
    mul_valid1 = base1 || (hold1 > 0);
  end

  bit           pr0 = 1'b1;
  bit           pr1 = 1'b1;
  int           kicks0 = 0;
  int           kicks1 = 0;
  int           dc0 = 0;
  int           dc1 = 0;
  logic [511:0] ops1[$];

  always @(posedge clk) begin
    pr0 <= (mul_rst0 !== 1'b0);
    pr1 <= (mul_rst1 !== 1'b0);
    if (pr0 && mul_rst0 === 1'b0) kicks0 <= kicks0 + 1;
    if (pr1 && mul_rst1 === 1'b0) begin
      kicks1 <= kicks1 + 1;
      ops1.push_back({mul_a1, mul_b1});
    end
    if (done0 === 1'b1) dc0 <= dc0 + 1;
    if (done1 === 1'b1) dc1 <= dc1 + 1;
  end

  logic [255:0] q0[$];
  logic [255:0] q1[$];

  task automatic run(input bit sel, input logic [255:0] a, input int limit,
                     output logic [255:0] res, output int lat,
                     output int bad, output logic bdone);
    @(posedge clk); #1;
    if (sel) begin a1 = a; start1 = 1'b1; end
    else     begin a0 = a; start0 = 1'b1; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 0;
    bad = 0;
    bdone = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if ((sel ? done1 : done0) === 1'b1) begin
        lat = n;
        bdone = sel ? busy1 : busy0;
        break;
      end
      if ((sel ? busy1 : busy0) !== 1'b1) bad++;
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout sel=%0d: no done within %0d cycles", sel, limit);
    end
    @(negedge clk);
    res = sel ? result1 : result0;
  endtask

  task automatic test_reset();
    start0 = 1'b1;
    start1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy0, done0, mul_rst0, mul_redux0} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0011", {busy0, done0, mul_rst0, mul_redux0});
    end
    checks++;
    if (result0 !== '0 || mul_a0 !== '0 || mul_b0 !== '0) begin
      errors++;
      $display("FAIL reset_data got result=%h a=%h b=%h want 0", result0, mul_a0, mul_b0);
    end
    checks++;
    if (busy1 !== 1'b0 || result1 !== '0) begin
      errors++;
      $display("FAIL reset_small got busy=%b result=%h want 0/0", busy1, result1);
    end
  endtask

  task automatic test_unit();
    logic [255:0] r, e;
    int lat, bad, kb, db;
    logic bd;
    lm0 = 4;
    kb = kicks0;
    db = dc0;
    q0.push_back(256'd1);
    run(1'b0, 256'd1, 4000, r, lat, bad, bd);
    e = q0.pop_front();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL unit_result got=%h want=%h", r, e);
    end
    checks++;
    if (lat != 2532) begin
      errors++;
      $display("FAIL unit_latency got=%0d want=2532", lat);
    end
    checks++;
    if (kicks0 - kb != 506) begin
      errors++;
      $display("FAIL unit_kicks got=%0d want=506", kicks0 - kb);
    end
    checks++;
    if (dc0 - db != 1) begin
      errors++;
      $display("FAIL unit_done_pulses got=%0d want=1", dc0 - db);
    end
  endtask

  task automatic test_inv2_midstart();
    logic [255:0] r, e;
    int lat, bad, db;
    logic bd;
    lm0 = 4;
    db = dc0;
    q0.push_back((256'd1 << 254) - 256'd9);
    fork
      run(1'b0, 256'd2, 4000, r, lat, bad, bd);
      begin
        repeat (300) @(posedge clk);
        #1;
        a0 = 256'd5;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
      end
    join
    e = q0.pop_front();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL inv2_result got=%h want=%h", r, e);
    end
    checks++;
    if (mm(r, 256'd2) !== 256'd1) begin
      errors++;
      $display("FAIL inv2_product got=%h want=1", mm(r, 256'd2));
    end
    repeat (10) @(negedge clk);
    checks++;
    if (dc0 - db != 1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midstart_ignored got pulses=%0d busy=%b want 1/0", dc0 - db, busy0);
    end
  endtask

  task automatic test_abort();
    logic [255:0] r;
    int lat, bad, kb, db;
    logic bd;
    bit hit;
    lm0 = 1;
    kb = kicks0;
    db = dc0;
    hit = 1'b0;
    @(posedge clk); #1;
    a0 = 256'd7;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (kicks0 - kb >= 100) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach got kicks=%0d want 100", kicks0 - kb);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || result0 !== '0 || mul_rst0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_state got busy=%b result=%h mul_rst=%b want 0/0/1",
               busy0, result0, mul_rst0);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (dc0 != db) begin
      errors++;
      $display("FAIL abort_no_done got pulses=%0d want 0", dc0 - db);
    end
    run(1'b0, 256'd5, 2000, r, lat, bad, bd);
    checks++;
    if (mm(r, 256'd5) !== 256'd1) begin
      errors++;
      $display("FAIL abort_restart got=%h (x5=%h) want x5=1", r, mm(r, 256'd5));
    end
    checks++;
    if (lat != 1014) begin
      errors++;
      $display("FAIL abort_restart_latency got=%0d want=1014", lat);
    end
  endtask

  task automatic test_neg_one_zero();
    logic [255:0] r, e;
    int lat, bad;
    logic bd;
    lm0 = 1;
    q0.push_back(P - 256'd1);
    run(1'b0, P - 256'd1, 2000, r, lat, bad, bd);
    e = q0.pop_front();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL neg_one_result got=%h want=%h", r, e);
    end
    q0.push_back(256'd0);
    run(1'b0, 256'd0, 2000, r, lat, bad, bd);
    e = q0.pop_front();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL zero_result got=%h want=%h", r, e);
    end
    checks++;
    if (bad != 0 || bd !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy got low_cycles=%0d busy_at_done=%b want 0/0", bad, bd);
    end
  endtask

  task automatic test_small_order();
    logic [255:0] r, e;
    logic [511:0] want[3];
    logic [511:0] got;
    int lat, bad;
    logic bd;
    lm1 = 1;
    want[0] = {256'd3, 256'd3};
    want[1] = {256'd9, 256'd9};
    want[2] = {256'd81, 256'd3};
    ops1.delete();
    q1.push_back(256'd243);
    run(1'b1, 256'd3, 200, r, lat, bad, bd);
    e = q1.pop_front();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL small_result got=%0d want=%0d", r, e);
    end
    checks++;
    if (ops1.size() != 3) begin
      errors++;
      $display("FAIL small_op_count got=%0d want=3", ops1.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < ops1.size()) ? ops1[i] : '0;
      checks++;
      if (got !== want[i]) begin
        errors++;
        $display("FAIL small_op%0d got=(%0d,%0d) want=(%0d,%0d)", i,
                 got[511:256], got[255:0], want[i][511:256], want[i][255:0]);
      end
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL small_latency got=%0d want=8", lat);
    end
  endtask

  task automatic test_hold_and_stall();
    logic [255:0] r, e;
    int lat, bad, kb, db;
    logic bd;
    lm1 = 1;
    hold_en = 1'b1;
    kb = kicks1;
    db = dc1;
    q1.push_back(256'd243);
    run(1'b1, 256'd3, 200, r, lat, bad, bd);
    repeat (5) @(negedge clk);
    hold_en = 1'b0;
    e = q1.pop_front();
    checks++;
    if (r !== e || kicks1 - kb != 3 || dc1 - db != 1) begin
      errors++;
      $display("FAIL hold_valid got result=%0d ops=%0d pulses=%0d want 243/3/1",
               r, kicks1 - kb, dc1 - db);
    end
    lm1 = 20;
    q1.push_back(256'd243);
    run(1'b1, 256'd3, 500, r, lat, bad, bd);
    e = q1.pop_front();
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL stall20_result got=%0d want=%0d", r, e);
    end
    checks++;
    if (lat != 65) begin
      errors++;
      $display("FAIL stall20_latency got=%0d want=65", lat);
    end
    lm1 = 1;
  endtask

  initial begin
    test_reset();
    test_unit();
    test_inv2_midstart();
    test_abort();
    test_neg_one_zero();
    test_small_order();
    test_hold_and_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
